// File: rtl/spi_frame_parser.sv
// SPI byte-stream frame parser: CMD_PIXEL, 16-bit length, payload to FIFO, optional XOR checksum byte.
// Defining FRAME_CHECKSUM_EN enables the CHECK state and o_err_chk; otherwise frames end after the payload.
module spi_frame_parser #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter logic [7:0]  CMD_PIXEL = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_dataValid,
    input  logic       i_spi_nss,
    input  logic       i_wfull,
    output logic [7:0] o_wdata,
    output logic       o_winc,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_err_overflow,
    output logic       o_err_abort,
    output logic       o_err_cmd,
    output logic       o_err_chk
);

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_H   = 3'd1,
        ST_LEN_L   = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DISCARD = 3'd4,
        ST_CHECK   = 3'd5
    } state_e;
    localparam state_e ST_AFTER_PAY = ST_CHECK;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_H   = 3'd1,
        ST_LEN_L   = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;
    localparam state_e ST_AFTER_PAY = ST_IDLE;
`endif

    localparam logic [LEN_WIDTH-1:0] CNT_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] CNT_ZERO = {LEN_WIDTH{1'b0}};

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    state_e               state_q, state_d, byte_state_s;
    logic                 nss_meta_q, nss_sync_q, nss_prev_q;
    logic                 frame_end_s, abort_s, is_cmd_s;
    logic [7:0]           len_hi_q, len_hi_d;
    logic [15:0]          len_full_s;
    logic [LEN_WIDTH-1:0] len_cap_s, cnt_q, cnt_d;
    logic                 len_zero_s, last_s;
    logic [7:0]           xor_q, xor_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 winc_q, winc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_abt_q, err_abt_d;
    logic                 err_cmd_q, err_cmd_d;
`ifdef FRAME_CHECKSUM_EN
    logic                 err_chk_q, err_chk_d;
`else
    logic                 done_pend_q, done_pend_d;
`endif

    // Two-flop synchronizer plus edge history for the asynchronous chip select
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            nss_meta_q <= 1'b1;
            nss_sync_q <= 1'b1;
            nss_prev_q <= 1'b1;
        end else begin
            nss_meta_q <= i_spi_nss;
            nss_sync_q <= nss_meta_q;
            nss_prev_q <= nss_sync_q;
        end
    end

    assign frame_end_s = nss_sync_q & ~nss_prev_q;
    assign is_cmd_s    = (i_rx_data == CMD_PIXEL);
    assign len_full_s  = {len_hi_q, i_rx_data};
    assign len_cap_s   = len_full_s[LEN_WIDTH-1:0];
    assign len_zero_s  = (len_cap_s == CNT_ZERO);
    assign last_s      = (cnt_q == CNT_ONE);

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: apply the received byte first, then a coincident frame end
    always_comb begin
        byte_state_s = state_q;
        if (i_rx_dataValid) begin
            case (state_q)
                ST_IDLE:    byte_state_s = is_cmd_s ? ST_LEN_H : ST_DISCARD;
                ST_LEN_H:   byte_state_s = ST_LEN_L;
                ST_LEN_L:   byte_state_s = len_zero_s ? ST_AFTER_PAY : ST_PAYLOAD;
                ST_PAYLOAD: byte_state_s = last_s ? ST_AFTER_PAY : ST_PAYLOAD;
`ifdef FRAME_CHECKSUM_EN
                ST_CHECK:   byte_state_s = ST_IDLE;
`endif
                ST_DISCARD: byte_state_s = ST_DISCARD;
                default:    byte_state_s = ST_IDLE;
            endcase
        end else begin
            byte_state_s = state_q;
        end
        if (frame_end_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = byte_state_s;
        end
    end

    // Frame end only counts as an abort while a frame is still being parsed
    assign abort_s = frame_end_s && (byte_state_s != ST_IDLE) && (byte_state_s != ST_DISCARD);

    // Output and datapath next-state: length, countdown, checksum, FIFO writes, flags
    always_comb begin
        len_hi_d  = len_hi_q;
        cnt_d     = cnt_q;
        xor_d     = xor_q;
        wdata_d   = wdata_q;
        winc_d    = 1'b0;
        done_d    = 1'b0;
        err_ovf_d = err_ovf_q;
        err_abt_d = err_abt_q;
        err_cmd_d = err_cmd_q;
`ifdef FRAME_CHECKSUM_EN
        err_chk_d = err_chk_q;
`else
        done_pend_d = 1'b0;
        done_d      = done_pend_q;
`endif
        busy_d = (state_d != ST_IDLE);
        if (i_rx_dataValid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_cmd_s) begin
                        len_hi_d  = 8'h00;
                        cnt_d     = CNT_ZERO;
                        xor_d     = 8'h00;
                        err_ovf_d = 1'b0;
                        err_abt_d = 1'b0;
                        err_cmd_d = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                        err_chk_d = 1'b0;
`endif
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
                ST_LEN_H: len_hi_d = i_rx_data;
                ST_LEN_L: begin
                    cnt_d = len_cap_s;
`ifndef FRAME_CHECKSUM_EN
                    done_pend_d = len_zero_s;
`endif
                end
                ST_PAYLOAD: begin
                    cnt_d = cnt_q - CNT_ONE;
                    xor_d = chk_update(xor_q, i_rx_data);
                    if (i_wfull) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        wdata_d = i_rx_data;
                        winc_d  = 1'b1;
                    end
`ifndef FRAME_CHECKSUM_EN
                    done_pend_d = last_s;
`endif
                end
`ifdef FRAME_CHECKSUM_EN
                ST_CHECK: begin
                    if (i_rx_data == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_chk_d = 1'b1;
                    end
                end
`endif
                ST_DISCARD: len_hi_d = len_hi_q;
                default:    len_hi_d = len_hi_q;
            endcase
        end else begin
            winc_d = 1'b0;
        end
        if (abort_s) begin
            err_abt_d = 1'b1;
        end else begin
            err_abt_d = err_abt_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            len_hi_q  <= 8'h00;
            cnt_q     <= CNT_ZERO;
            xor_q     <= 8'h00;
            wdata_q   <= 8'h00;
            winc_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_ovf_q <= 1'b0;
            err_abt_q <= 1'b0;
            err_cmd_q <= 1'b0;
        end else begin
            len_hi_q  <= len_hi_d;
            cnt_q     <= cnt_d;
            xor_q     <= xor_d;
            wdata_q   <= wdata_d;
            winc_q    <= winc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_ovf_q <= err_ovf_d;
            err_abt_q <= err_abt_d;
            err_cmd_q <= err_cmd_d;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Checksum mismatch flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            err_chk_q <= 1'b0;
        end else begin
            err_chk_q <= err_chk_d;
        end
    end
    assign o_err_chk = err_chk_q;
`else
    // Completion is delayed one cycle so it never overlaps the final FIFO write
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            done_pend_q <= 1'b0;
        end else begin
            done_pend_q <= done_pend_d;
        end
    end
    assign o_err_chk = 1'b0;
`endif

    assign o_wdata        = wdata_q;
    assign o_winc         = winc_q;
    assign o_busy         = busy_q;
    assign o_frame_done   = done_q;
    assign o_err_overflow = err_ovf_q;
    assign o_err_abort    = err_abt_q;
    assign o_err_cmd      = err_cmd_q;

endmodule

// File: tb/tb_spi_frame_parser.sv
// Self-checking bench for spi_frame_parser: directed frames plus random frames checked against a frame-level model.
module tb_spi_frame_parser;
    localparam logic [7:0] CMD = 8'hA5;
`ifdef FRAME_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid, nss, wfull;
    logic [7:0] o_wdata;
    logic       o_winc, o_busy, o_frame_done;
    logic       o_err_overflow, o_err_abort, o_err_cmd, o_err_chk;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    logic m_ovf, m_abt, m_cmd, m_chk;
    logic [7:0] frm_b[$];
    logic       frm_wf[$];

    always #5 clk = ~clk;

    spi_frame_parser dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_dataValid(rx_valid),
        .i_spi_nss(nss), .i_wfull(wfull), .o_wdata(o_wdata), .o_winc(o_winc),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err_overflow(o_err_overflow),
        .o_err_abort(o_err_abort), .o_err_cmd(o_err_cmd), .o_err_chk(o_err_chk)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (o_frame_done === 1'b1) done_seen++;
            if (o_winc === 1'b1 || o_frame_done === 1'b1)
                check("winc_done_exclusive", {31'd0, o_winc & o_frame_done}, 32'd0);
        end
    end

    task automatic push(input logic [7:0] b, input logic wf);
        frm_b.push_back(b);
        frm_wf.push_back(wf);
    endtask

    task automatic clear_frame();
        frm_b.delete();
        frm_wf.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic wf, input logic exp_winc,
                             input logic exp_busy, input string tag);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1; wfull = wf;
        @(posedge clk); #1;
        check({tag, "_winc"}, {31'd0, o_winc}, {31'd0, exp_winc});
        if (exp_winc) check({tag, "_wdata"}, {24'd0, o_wdata}, {24'd0, b});
        check({tag, "_busy"}, {31'd0, o_busy}, {31'd0, exp_busy});
        @(negedge clk);
        rx_valid = 1'b0; wfull = 1'($urandom_range(0, 1)); rx_data = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovf"}, {31'd0, o_err_overflow}, {31'd0, m_ovf});
        check({tag, "_abort"}, {31'd0, o_err_abort}, {31'd0, m_abt});
        check({tag, "_cmd"}, {31'd0, o_err_cmd}, {31'd0, m_cmd});
        check({tag, "_chk"}, {31'd0, o_err_chk}, {31'd0, m_chk});
    endtask

    // Frame-level model: positions decide role (cmd, length, payload, checksum)
    task automatic run_frame(input string tag);
        int n, len, full, done_start, exp_done;
        logic complete, pay;
        logic [7:0] x;
        n = frm_b.size(); len = 0; full = 0; x = 8'h00; exp_done = 0; complete = 1'b0;
        if (frm_b[0] != CMD) begin
            m_cmd = 1'b1;
        end else begin
            m_ovf = 1'b0; m_abt = 1'b0; m_cmd = 1'b0; m_chk = 1'b0;
            if (n >= 3) len = int'({frm_b[1], frm_b[2]});
            full = 3 + len + CHK_BYTES;
            complete = (n >= 3) && (n >= full);
            for (int i = 3; i < n && i < 3 + len; i++) begin
                x ^= frm_b[i];
                if (frm_wf[i]) m_ovf = 1'b1;
            end
            if (!complete) m_abt = 1'b1;
            else if (CHK_BYTES == 1 && frm_b[3 + len] != x) m_chk = 1'b1;
            else exp_done = 1;
        end
        @(negedge clk); nss = 1'b0;
        repeat (3) @(negedge clk);
        done_start = done_seen;
        for (int i = 0; i < n; i++) begin
            pay = (frm_b[0] == CMD) && (n >= 3) && (i >= 3) && (i < 3 + len);
            send_byte(frm_b[i], frm_wf[i], pay && !frm_wf[i], !(complete && i == n - 1), tag);
        end
        @(negedge clk); nss = 1'b1;
        repeat (5) @(negedge clk);
        check({tag, "_busy_end"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_done_cnt"}, done_seen - done_start, exp_done);
        check_flags(tag);
    endtask

    task automatic gen_random(input int kind);
        int len, k;
        logic [7:0] x, b;
        clear_frame();
        if (kind == 0) begin
            b = 8'($urandom);
            if (b == CMD) b = 8'h3C;
            push(b, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 10)) push(8'($urandom), 1'($urandom_range(0, 1)));
        end else begin
            len = $urandom_range(0, 6);
            x = 8'h00;
            push(CMD, 1'($urandom_range(0, 1)));
            push(8'h00, 1'($urandom_range(0, 1)));
            push(8'(len), 1'($urandom_range(0, 1)));
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                x ^= b;
                push(b, ($urandom_range(0, 4) == 0));
            end
            if (CHK_BYTES == 1) begin
                if ($urandom_range(0, 3) == 0) push(x ^ 8'($urandom_range(1, 255)), 1'b0);
                else push(x, 1'b0);
            end
            if (kind == 2) begin
                k = $urandom_range(1, frm_b.size() - 1);
                while (frm_b.size() > k) begin
                    void'(frm_b.pop_back());
                    void'(frm_wf.pop_back());
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; nss = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; wfull = 1'b0;
        m_ovf = 1'b0; m_abt = 1'b0; m_cmd = 1'b0; m_chk = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wdata", {24'd0, o_wdata}, 32'd0);
        check("rst_winc", {31'd0, o_winc}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_frame_done}, 32'd0);
        check_flags("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic three-byte frame
        clear_frame();
        push(CMD, 0); push(8'h00, 0); push(8'h03, 0);
        push(8'h11, 0); push(8'h22, 0); push(8'h44, 0);
        if (CHK_BYTES == 1) push(8'h77, 0);
        run_frame("good3");

        // Same frame with a wrong checksum byte
        if (CHK_BYTES == 1) begin
            clear_frame();
            push(CMD, 0); push(8'h00, 0); push(8'h03, 0);
            push(8'h11, 0); push(8'h22, 0); push(8'h44, 0); push(8'h76, 0);
            run_frame("badchk");
        end

        // FIFO full on second payload byte
        clear_frame();
        push(CMD, 0); push(8'h00, 0); push(8'h04, 0);
        push(8'h01, 0); push(8'h02, 1); push(8'h03, 0); push(8'h04, 0);
        if (CHK_BYTES == 1) push(8'h04, 0);
        run_frame("ovf");

        // Abort mid-payload, then a good frame clears the flag
        clear_frame();
        push(CMD, 0); push(8'h00, 0); push(8'h05, 0); push(8'h10, 0); push(8'h20, 0);
        run_frame("abort");
        clear_frame();
        push(CMD, 0); push(8'h00, 0); push(8'h01, 0); push(8'h5A, 0);
        if (CHK_BYTES == 1) push(8'h5A, 0);
        run_frame("after_abort");

        // Bad command followed by ten ignored bytes
        clear_frame();
        push(8'h3C, 0);
        for (int i = 0; i < 10; i++) push(8'(i * 17 + 3), 0);
        run_frame("badcmd");

        // Zero-length frame
        clear_frame();
        push(CMD, 0); push(8'h00, 0); push(8'h00, 0);
        if (CHK_BYTES == 1) push(8'h00, 0);
        run_frame("len0");

        // Reset in the middle of a payload
        @(negedge clk); nss = 1'b0;
        repeat (3) @(negedge clk);
        send_byte(CMD, 1'b0, 1'b0, 1'b1, "rstmid");
        send_byte(8'h00, 1'b0, 1'b0, 1'b1, "rstmid");
        send_byte(8'h05, 1'b0, 1'b0, 1'b1, "rstmid");
        send_byte(8'hC3, 1'b0, 1'b1, 1'b1, "rstmid");
        @(negedge clk); #2 rst = 1'b1;
        #1;
        m_ovf = 1'b0; m_abt = 1'b0; m_cmd = 1'b0; m_chk = 1'b0;
        check("rstmid_wdata", {24'd0, o_wdata}, 32'd0);
        check("rstmid_winc", {31'd0, o_winc}, 32'd0);
        check("rstmid_busy", {31'd0, o_busy}, 32'd0);
        check_flags("rstmid");
        @(negedge clk); rst = 1'b0; nss = 1'b1;
        repeat (4) @(negedge clk);
        clear_frame();
        push(CMD, 0); push(8'h00, 0); push(8'h02, 0); push(8'hAB, 0); push(8'hCD, 0);
        if (CHK_BYTES == 1) push(8'h66, 0);
        run_frame("post_rst");

        // Random frames: bad command, complete, truncated
        for (int f = 0; f < 40; f++) begin
            gen_random($urandom_range(0, 2));
            run_frame("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
